// File: rtl/hex_line_serializer.sv
// Hex line serializer: captures one word of ASCII hex characters and streams
// it most-significant character first over a valid/ready byte interface,
// optionally terminated by CR LF.
module hex_line_serializer #(
  parameter int NBR_OF_NIBBLES = 4,
  parameter bit APPEND_CRLF    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NBR_OF_NIBBLES*8-1:0] ascii_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy
);

  // A single-character word still needs a 1-bit index register.
  localparam int IW = (NBR_OF_NIBBLES > 1) ? $clog2(NBR_OF_NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND_CHAR, SEND_CR, SEND_LF} state_t;

  state_t                             state_q, state_d;
  logic [IW-1:0]                      idx_q, idx_nxt;
  logic [NBR_OF_NIBBLES-1:0][7:0]     word_q;
  logic [7:0]                         data_q, nxt_byte;
  logic                               acc, xfer;

  assign in_ready = (state_q == IDLE);
  assign tx_valid = (state_q != IDLE);
  assign busy     = tx_valid;
  assign tx_data  = data_q;
  assign acc      = in_valid && in_ready;
  assign xfer     = tx_valid && tx_ready;
  assign idx_nxt  = idx_q - 1'b1;

  // Select the next lower character of the captured word.
  always_comb begin
    nxt_byte = '0;
    for (int i = 0; i < NBR_OF_NIBBLES; i++)
      if (IW'(i) == idx_nxt) nxt_byte = word_q[i];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; every move out of a sending state needs a transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (acc) state_d = SEND_CHAR;
      SEND_CHAR: if (xfer && idx_q == '0) state_d = APPEND_CRLF ? SEND_CR : IDLE;
      SEND_CR:   if (xfer) state_d = SEND_LF;
      SEND_LF:   if (xfer) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: tx_data is registered so it holds its last value in IDLE and
  // stays stable while the transmitter stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      idx_q  <= '0;
      data_q <= 8'h00;
    end else if (acc) begin
      word_q <= ascii_in;
      idx_q  <= IW'(NBR_OF_NIBBLES - 1);
      data_q <= ascii_in[NBR_OF_NIBBLES*8-1 -: 8];
    end else if (xfer) begin
      case (state_q)
        SEND_CHAR: begin
          if (idx_q != '0) begin
            idx_q  <= idx_nxt;
            data_q <= nxt_byte;
          end else if (APPEND_CRLF) begin
            data_q <= 8'h0D;
          end
        end
        SEND_CR: data_q <= 8'h0A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_line_serializer.sv
// Bench for hex_line_serializer: a queue-of-bytes reference model drives
// cycle checks on a 4-char CRLF instance; small directed runs cover the
// 2-char no-terminator and 1-char configurations.
module tb_hex_line_serializer;

  localparam int NB = 4;
  localparam bit CR = 1'b1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // main instance
  logic [NB*8-1:0] ascii_in;
  logic in_valid, in_ready, tx_valid, tx_ready, busy;
  logic [7:0] tx_data;

  hex_line_serializer #(.NBR_OF_NIBBLES(NB), .APPEND_CRLF(CR)) dut (
    .clk(clk), .reset_n(reset_n), .ascii_in(ascii_in), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy));

  // 2 chars, no terminator
  logic [15:0] d2_ascii;
  logic d2_in_valid, d2_in_ready, d2_tx_valid, d2_tx_ready, d2_busy;
  logic [7:0] d2_tx_data;

  hex_line_serializer #(.NBR_OF_NIBBLES(2), .APPEND_CRLF(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .ascii_in(d2_ascii), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .tx_data(d2_tx_data), .tx_valid(d2_tx_valid),
    .tx_ready(d2_tx_ready), .busy(d2_busy));

  // 1 char with terminator
  logic [7:0] d3_ascii;
  logic d3_in_valid, d3_in_ready, d3_tx_valid, d3_tx_ready, d3_busy;
  logic [7:0] d3_tx_data;

  hex_line_serializer #(.NBR_OF_NIBBLES(1), .APPEND_CRLF(1'b1)) dut3 (
    .clk(clk), .reset_n(reset_n), .ascii_in(d3_ascii), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .tx_data(d3_tx_data), .tx_valid(d3_tx_valid),
    .tx_ready(d3_tx_ready), .busy(d3_busy));

  int checks = 0;
  int errors = 0;

  // reference model: bytes still owed to the transmitter, plus last byte shown
  logic [7:0] q[$];
  logic [7:0] last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [NB*8-1:0] a);
    for (int i = NB - 1; i >= 0; i--) q.push_back(a[i*8 +: 8]);
    if (CR) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endtask

  // Called at posedge+1: check outputs, drive inputs, advance model one cycle.
  task automatic step(input logic iv, input logic [NB*8-1:0] a, input logic tr);
    logic ev;
    ev = (q.size() != 0);
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, ev});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !ev});
    chk("busy",     {31'd0, busy},     {31'd0, ev});
    chk("tx_data",  {24'd0, tx_data},  {24'd0, ev ? q[0] : last});
    in_valid = iv;
    ascii_in = a;
    tx_ready = tr;
    if (ev && tr)       last = q.pop_front();
    else if (!ev && iv) push_word(a);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; ascii_in = '0; tx_ready = 1'b0;
    d2_in_valid = 1'b0; d2_ascii = '0; d2_tx_ready = 1'b1;
    d3_in_valid = 1'b0; d3_ascii = '0; d3_tx_ready = 1'b1;
    #2;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data},  32'h00);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // basic line, accepted on first edge after release, tx_ready high
    step(1'b1, 32'h31413246, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // stall three cycles while 41 is shown
    step(1'b1, 32'h31413246, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // in_valid held high with changing data: one bubble between lines
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // mid-line reset while 32 is shown
    step(1'b1, 32'h31413246, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("pre_rst_data", {24'd0, tx_data}, 32'h32);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_tx_data",  {24'd0, tx_data},  32'h00);
    q.delete();
    last = 8'h00;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h30303030, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    // 2-char word, no terminator
    chk("d2_idle_ready", {31'd0, d2_in_ready}, 32'd1);
    d2_in_valid = 1'b1; d2_ascii = 16'h4630;
    @(posedge clk); #1;
    d2_in_valid = 1'b0; d2_ascii = 16'hFFFF;
    chk("d2_c0_valid", {31'd0, d2_tx_valid}, 32'd1);
    chk("d2_c0_data",  {24'd0, d2_tx_data},  32'h46);
    chk("d2_c0_ready", {31'd0, d2_in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("d2_c1_valid", {31'd0, d2_tx_valid}, 32'd1);
    chk("d2_c1_data",  {24'd0, d2_tx_data},  32'h30);
    @(posedge clk); #1;
    chk("d2_end_valid", {31'd0, d2_tx_valid}, 32'd0);
    chk("d2_end_ready", {31'd0, d2_in_ready}, 32'd1);
    chk("d2_end_busy",  {31'd0, d2_busy},     32'd0);
    chk("d2_end_data",  {24'd0, d2_tx_data},  32'h30);

    // 1-char word with terminator
    d3_in_valid = 1'b1; d3_ascii = 8'h39;
    @(posedge clk); #1;
    d3_in_valid = 1'b0;
    chk("d3_c0_data",  {24'd0, d3_tx_data},  32'h39);
    chk("d3_c0_valid", {31'd0, d3_tx_valid}, 32'd1);
    @(posedge clk); #1;
    chk("d3_cr_data",  {24'd0, d3_tx_data},  32'h0D);
    @(posedge clk); #1;
    chk("d3_lf_data",  {24'd0, d3_tx_data},  32'h0A);
    chk("d3_lf_valid", {31'd0, d3_tx_valid}, 32'd1);
    @(posedge clk); #1;
    chk("d3_end_valid", {31'd0, d3_tx_valid}, 32'd0);
    chk("d3_end_ready", {31'd0, d3_in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
